// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path: default sizes, the
// writeback request bundle and the round-robin priority state.
package regfile_pkg;

    localparam int NUM_REGS_DEF = 32;
    localparam int REG_W_DEF    = 32;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] rd;
        logic [REG_W_DEF-1:0]  data;
    } wb_req_t;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with its own priority register; the grant is
// combinational from the requests, and the winner hands priority to the other side.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    arb_state_e r_state;

    // Ties go to the favoured side; a lone request always wins; nothing during reset.
    always_comb begin
        o_gnt = 2'b00;
        if (!reset) begin
            if (i_req == 2'b11) begin
                o_gnt = (r_state == PRI0) ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PRI0;
        end else if (o_gnt[0]) begin
            r_state <= PRI1;
        end else if (o_gnt[1]) begin
            r_state <= PRI0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between two writeback requesters with a
// one-cycle registered output stage. Optional forwarding ports: RF_WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int REG_W    = REG_W_DEF,
    parameter int CNT_W    = 16,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [REG_W-1:0]  req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [REG_W-1:0]  req1_data,
    output logic              req1_ready,
`ifdef RF_WB_BYPASS_EN
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              byp_hit_rs,
    output logic [REG_W-1:0]  byp_data_rs,
    output logic              byp_hit_rt,
    output logic [REG_W-1:0]  byp_data_rt,
`endif
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [REG_W-1:0]  rf_write_data,
    output logic [CNT_W-1:0]  conflict_count
);

    logic [1:0]        w_gnt;
    logic              w_anyGnt;
    logic [ADDR_W-1:0] w_gntRd;
    logic [REG_W-1:0]  w_gntData;

    logic              r_we;
    logic [ADDR_W-1:0] r_rd;
    logic [REG_W-1:0]  r_data;
    logic [CNT_W-1:0]  r_conflict;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .i_req ({req1_valid, req0_valid}),
        .o_gnt (w_gnt)
    );

    assign req0_ready = w_gnt[0];
    assign req1_ready = w_gnt[1];
    assign w_anyGnt   = |w_gnt;
    assign w_gntRd    = w_gnt[1] ? req1_rd   : req0_rd;
    assign w_gntData  = w_gnt[1] ? req1_data : req0_data;

    // Writes to r0 are accepted upstream but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else if (w_anyGnt && (w_gntRd != '0)) begin
            r_we   <= 1'b1;
            r_rd   <= w_gntRd;
            r_data <= w_gntData;
        end else begin
            r_we   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict <= '0;
        end else if (req0_valid && req1_valid && (r_conflict != '1)) begin
            r_conflict <= r_conflict + CNT_W'(1);
        end
    end

    // A write still sitting in the output stage is dropped as soon as reset rises.
    assign rf_write_enable = r_we && !reset;
    assign rf_rd           = r_rd;
    assign rf_write_data   = r_data;
    assign conflict_count  = r_conflict;

`ifdef RF_WB_BYPASS_EN
    assign byp_hit_rs  = rf_write_enable && (rf_rd == rs) && (rs != '0);
    assign byp_data_rs = byp_hit_rs ? rf_write_data : '0;
    assign byp_hit_rt  = rf_write_enable && (rf_rd == rt) && (rt != '0);
    assign byp_data_rt = byp_hit_rt ? rf_write_data : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random
// traffic against a cycle-level reference model. Covers RF_WB_BYPASS_EN when defined.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int ADDR_W = 5;
    localparam int REG_W  = 32;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_rd, req1_rd;
    logic [REG_W-1:0]  req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_rd;
    logic [REG_W-1:0]  rf_write_data;
    logic [CNT_W-1:0]  conflict_count;
    logic [ADDR_W-1:0] rs, rt;
`ifdef RF_WB_BYPASS_EN
    logic              byp_hit_rs, byp_hit_rt;
    logic [REG_W-1:0]  byp_data_rs, byp_data_rt;
`endif

    regfile_wb_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_rd         (req0_rd),
        .req0_data       (req0_data),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_rd         (req1_rd),
        .req1_data       (req1_data),
        .req1_ready      (req1_ready),
`ifdef RF_WB_BYPASS_EN
        .rs              (rs),
        .rt              (rt),
        .byp_hit_rs      (byp_hit_rs),
        .byp_data_rs     (byp_data_rs),
        .byp_hit_rt      (byp_hit_rt),
        .byp_data_rt     (byp_data_rt),
`endif
        .rf_write_enable (rf_write_enable),
        .rf_rd           (rf_rd),
        .rf_write_data   (rf_write_data),
        .conflict_count  (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compareCount = 0;
    int failCount    = 0;

    // Reference model: who wins the next tie, the pending register-file write, the counter.
    bit                mReq1Favoured;
    bit                mWe;
    logic [ADDR_W-1:0] mRd;
    logic [REG_W-1:0]  mData;
    int unsigned       mCnt;
    bit                expG0, expG1;

    logic              lastReady0, lastReady1, lastWe;
`ifdef RF_WB_BYPASS_EN
    logic              lastHitRs, lastHitRt;
    logic [REG_W-1:0]  lastDataRs, lastDataRt;
`endif

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check the settled cycle against the model, clock, advance the model.
    task automatic applyStimulus(input bit rst,
                                 input bit v0, input logic [ADDR_W-1:0] rd0, input logic [REG_W-1:0] d0,
                                 input bit v1, input logic [ADDR_W-1:0] rd1, input logic [REG_W-1:0] d1,
                                 input logic [ADDR_W-1:0] srcS, input logic [ADDR_W-1:0] srcT,
                                 input bit doCheck);
        bit expWe;
        reset      = rst;
        req0_valid = v0;  req0_rd = rd0;  req0_data = d0;
        req1_valid = v1;  req1_rd = rd1;  req1_data = d1;
        rs = srcS;  rt = srcT;
        #1;
        expG0 = !rst && v0 && (!v1 || !mReq1Favoured);
        expG1 = !rst && v1 && (!v0 || mReq1Favoured);
        expWe = mWe && !rst;
        lastReady0 = req0_ready;
        lastReady1 = req1_ready;
        lastWe     = rf_write_enable;
`ifdef RF_WB_BYPASS_EN
        lastHitRs = byp_hit_rs;  lastDataRs = byp_data_rs;
        lastHitRt = byp_hit_rt;  lastDataRt = byp_data_rt;
`endif
        if (doCheck) begin
            checkOutput("req0_ready", req0_ready, expG0);
            checkOutput("req1_ready", req1_ready, expG1);
            checkOutput("rf_write_enable", rf_write_enable, expWe);
            checkOutput("rf_rd", rf_rd, mRd);
            checkOutput("rf_write_data", rf_write_data, mData);
            checkOutput("conflict_count", conflict_count, mCnt);
`ifdef RF_WB_BYPASS_EN
            checkOutput("byp_hit_rs", byp_hit_rs, expWe && (mRd == srcS) && (srcS != 0));
            checkOutput("byp_data_rs", byp_data_rs, (expWe && (mRd == srcS) && (srcS != 0)) ? mData : '0);
            checkOutput("byp_hit_rt", byp_hit_rt, expWe && (mRd == srcT) && (srcT != 0));
            checkOutput("byp_data_rt", byp_data_rt, (expWe && (mRd == srcT) && (srcT != 0)) ? mData : '0);
`endif
        end
        @(posedge clk);
        if (rst) begin
            mReq1Favoured = 1'b0;
            mWe   = 1'b0;
            mRd   = '0;
            mData = '0;
            mCnt  = 0;
        end else begin
            mWe = 1'b0;
            if (expG0) begin
                mReq1Favoured = 1'b1;
                if (rd0 != 0) begin mWe = 1'b1; mRd = rd0; mData = d0; end
            end else if (expG1) begin
                mReq1Favoured = 1'b0;
                if (rd1 != 0) begin mWe = 1'b1; mRd = rd1; mData = d1; end
            end
            if (v0 && v1 && mCnt < 65535) mCnt++;
        end
        #1;
    endtask

    task automatic idleCycle(input bit rst);
        applyStimulus(rst, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0, 1'b1);
    endtask

    logic [ADDR_W-1:0] writeOrder[$];
    bit                p0v, p1v;
    logic [ADDR_W-1:0] p0rd, p1rd, srcS, srcT;
    logic [REG_W-1:0]  p0d, p1d;

    initial begin
        mReq1Favoured = 1'b0;  mWe = 1'b0;  mRd = '0;  mData = '0;  mCnt = 0;

        // Reset state and a lone req0 write.
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("reset_we", rf_write_enable, 1'b0);
        checkOutput("reset_cnt", conflict_count, 16'h0);
        checkOutput("reset_state", dut.u_arb.r_state, PRI0);
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, '0, '0, 1'b1);
        checkOutput("t1_ready0", lastReady0, 1'b1);
        checkOutput("t1_we", rf_write_enable, 1'b1);
        checkOutput("t1_rd", rf_rd, 5'd5);
        checkOutput("t1_data", rf_write_data, 32'hDEAD_BEEF);
        checkOutput("t1_state", dut.u_arb.r_state, PRI1);

        // Both valid for four cycles from reset: strict alternation.
        idleCycle(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + i, '0, '0, 1'b1);
            if (rf_write_enable) writeOrder.push_back(rf_rd);
        end
        checkOutput("t2_nwrites", writeOrder.size(), 4);
        for (int i = 0; i < writeOrder.size(); i++) begin
            checkOutput("t2_order", writeOrder[i], (i % 2 == 0) ? 5'd1 : 5'd2);
        end
        checkOutput("t2_cnt", conflict_count, 16'd4);

        // r0 write from req1: accepted, flips priority, never written.
        applyStimulus(1'b0, 1'b1, 5'd3, 32'h33, 1'b0, '0, '0, '0, '0, 1'b1);
        checkOutput("t3_pre_state", dut.u_arb.r_state, PRI1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hABCD, '0, '0, 1'b1);
        checkOutput("t3_ready1", lastReady1, 1'b1);
        checkOutput("t3_we", rf_write_enable, 1'b0);
        checkOutput("t3_state", dut.u_arb.r_state, PRI0);

        // Reset arriving right after a grant discards the pending write.
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, '0, '0, 1'b1);
        idleCycle(1'b1);
        checkOutput("t4_we_n1", lastWe, 1'b0);
        checkOutput("t4_we_n2", rf_write_enable, 1'b0);
        checkOutput("t4_cnt", conflict_count, 16'h0);
        checkOutput("t4_state", dut.u_arb.r_state, PRI0);
        idleCycle(1'b0);
        checkOutput("t4_we_after", lastWe, 1'b0);

`ifdef RF_WB_BYPASS_EN
        // Forwarding from the output stage in the cycle before commit.
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h1234, 1'b0, '0, '0, '0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd7, 5'd0, 1'b1);
        checkOutput("t6_hit_rs", lastHitRs, 1'b1);
        checkOutput("t6_data_rs", lastDataRs, 32'h1234);
        checkOutput("t6_hit_rt", lastHitRt, 1'b0);
        checkOutput("t6_data_rt", lastDataRt, 32'h0);
`endif

        // Random traffic; requesters hold their request until it is accepted.
        p0v = 1'b0;  p1v = 1'b0;  expG0 = 1'b0;  expG1 = 1'b0;
        p0rd = '0;  p1rd = '0;  p0d = '0;  p1d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0v || expG0) begin
                p0v = ($urandom_range(0, 3) != 0);  p0rd = ADDR_W'($urandom_range(0, 31));  p0d = $urandom;
            end
            if (!p1v || expG1) begin
                p1v = ($urandom_range(0, 3) != 0);  p1rd = ADDR_W'($urandom_range(0, 31));  p1d = $urandom;
            end
            srcS = ($urandom_range(0, 1) != 0) ? mRd : ADDR_W'($urandom_range(0, 31));
            srcT = ($urandom_range(0, 1) != 0) ? mRd : ADDR_W'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 49) == 0, p0v, p0rd, p0d, p1v, p1rd, p1d, srcS, srcT, 1'b1);
        end

        // Counter saturation: both valid for 2^16+3 cycles.
        idleCycle(1'b1);
        for (int i = 0; i < 65539; i++) begin
            applyStimulus(1'b0, 1'b1, 5'd4, 32'(i), 1'b1, 5'd6, 32'(i), '0, '0, 1'b0);
        end
        checkOutput("t5_cnt_sat", conflict_count, 16'hFFFF);
        applyStimulus(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, '0, '0, 1'b1);
        checkOutput("t5_cnt_hold", conflict_count, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
